// File: rtl/mem_arbiter.sv
// Two-port BRAM arbiter: port 0 (core) has fixed priority, port 1 has starvation relief and burst lock.
// Optional grant statistics are enabled by defining MEM_ARB_STATS_EN.
module mem_arbiter #(
  parameter int unsigned ADDR_W   = 20,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  input  logic              p1_lock,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [31:0]       p0_cnt,
  output logic [31:0]       p1_cnt,
  output logic [15:0]       starve_cnt
`endif
);

  localparam logic [0:0] ST_ARB   = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam logic [7:0] WAIT_MAX = 8'(MAX_WAIT);

  logic [0:0]        state_q, state_d;
  logic [7:0]        wait_q, wait_d;
  logic              own0_q, own0_d;
  logic              own1_q, own1_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              gnt0, gnt1, forced;

  // Grants are held off while reset is asserted so nothing reaches the BRAM.
  always_comb begin
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    forced  = 1'b0;
    state_d = state_q;
    wait_d  = wait_q;
    if (rstn) begin
      if (state_q == ST_BURST) begin
        gnt1   = p1_req;
        wait_d = '0;
        if (!p1_lock) state_d = ST_ARB;
      end else begin
        gnt1   = p1_req && (!p0_req || (wait_q == WAIT_MAX));
        gnt0   = p0_req && !gnt1;
        forced = gnt1 && (wait_q == WAIT_MAX);
        if (gnt1) begin
          wait_d = '0;
          if (p1_lock) state_d = ST_BURST;
        end else if (p1_req) begin
          if (wait_q < WAIT_MAX) wait_d = wait_q + 8'd1;
        end else begin
          wait_d = '0;
        end
      end
    end
  end

  always_comb begin
    own0_d    = gnt0 && !p0_we;
    own1_d    = gnt1 && !p1_we;
    mem_we    = (gnt0 && p0_we) || (gnt1 && p1_we);
    mem_wdata = gnt1 ? p1_wdata : p0_wdata;
    if (gnt1)      mem_addr = p1_addr;
    else if (gnt0) mem_addr = p0_addr;
    else           mem_addr = addr_q;
    addr_d = mem_addr;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= ST_ARB;
      wait_q  <= '0;
      own0_q  <= 1'b0;
      own1_q  <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      own0_q  <= own0_d;
      own1_q  <= own1_d;
      addr_q  <= addr_d;
    end
  end

  assign p0_gnt    = gnt0;
  assign p1_gnt    = gnt1;
  assign p0_rvalid = own0_q;
  assign p1_rvalid = own1_q;
  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;

`ifdef MEM_ARB_STATS_EN
  logic [31:0] p0_cnt_q, p1_cnt_q;
  logic [15:0] starve_q;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      p0_cnt_q <= '0;
      p1_cnt_q <= '0;
      starve_q <= '0;
    end else begin
      if (gnt0) p0_cnt_q <= p0_cnt_q + 32'd1;
      if (gnt1) p1_cnt_q <= p1_cnt_q + 32'd1;
      if (forced && (starve_q != '1)) starve_q <= starve_q + 16'd1;
    end
  end

  assign p0_cnt     = p0_cnt_q;
  assign p1_cnt     = p1_cnt_q;
  assign starve_cnt = starve_q;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 1-cycle-latency BRAM model; stats checks need MEM_ARB_STATS_EN.
module tb_mem_arbiter;
  localparam int unsigned AW = 20;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 8;

  logic          clk, rstn;
  logic          p0_req, p0_we, p0_gnt, p0_rvalid;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_we, p1_gnt, p1_rvalid, p1_lock;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_wdata, mem_rdata;
`ifdef MEM_ARB_STATS_EN
  logic [31:0]   p0_cnt, p1_cnt;
  logic [15:0]   starve_cnt;
`endif

  int checks = 0;
  int fails  = 0;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clk(clk), .rstn(rstn),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .p1_lock(p1_lock),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
`ifdef MEM_ARB_STATS_EN
    , .p0_cnt(p0_cnt), .p1_cnt(p1_cnt), .starve_cnt(starve_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: read-first, contents preset to A5A5_0000 | index while reset is low.
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
    end else if (mem_we) begin
      mem[mem_addr[9:0]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[9:0]];
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rstn = 1'b0;
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0; p1_lock = 0;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    // Idle after reset
    for (int c = 0; c < 5; c++) begin
      #1;
      chk("idle_p0_gnt", p0_gnt, 0);
      chk("idle_p1_gnt", p1_gnt, 0);
      chk("idle_p0_rvalid", p0_rvalid, 0);
      chk("idle_p1_rvalid", p1_rvalid, 0);
      chk("idle_mem_we", mem_we, 0);
      chk("idle_mem_addr", mem_addr, 0);
`ifdef MEM_ARB_STATS_EN
      chk("idle_p0_cnt", p0_cnt, 0);
`endif
      @(negedge clk);
    end

    // p0 write then read back
    p0_req = 1; p0_we = 1; p0_addr = 20'h00010; p0_wdata = 32'hDEADBEEF;
    #1;
    chk("wr_p0_gnt", p0_gnt, 1);
    chk("wr_p1_gnt", p1_gnt, 0);
    chk("wr_mem_we", mem_we, 1);
    chk("wr_mem_addr", mem_addr, 20'h00010);
    chk("wr_mem_wdata", mem_wdata, 32'hDEADBEEF);
    @(negedge clk);
    p0_we = 0;
    #1;
    chk("rd_p0_gnt", p0_gnt, 1);
    chk("rd_mem_we", mem_we, 0);
    chk("wr_no_rvalid", p0_rvalid, 0);
    @(negedge clk);
    p0_req = 0;
    #1;
    chk("rd_p0_rvalid", p0_rvalid, 1);
    chk("rd_p0_rdata", p0_rdata, 32'hDEADBEEF);
    chk("rd_p1_rvalid", p1_rvalid, 0);
    chk("rd_p0_gnt_idle", p0_gnt, 0);
    chk("rd_addr_hold", mem_addr, 20'h00010);
    @(negedge clk);

    // Both ports request continuously: period of 9 with p1 winning last
    p0_req = 1; p0_we = 0; p0_addr = 20'h00020;
    p1_req = 1; p1_we = 0; p1_addr = 20'h00030;
    for (int i = 0; i < 18; i++) begin
      #1;
      chk("starve_p0_gnt", p0_gnt, (i % 9) != 8);
      chk("starve_p1_gnt", p1_gnt, (i % 9) == 8);
      chk("starve_mem_addr", mem_addr, ((i % 9) == 8) ? 20'h00030 : 20'h00020);
      if (i > 0) begin
        chk("starve_p1_rvalid", p1_rvalid, ((i - 1) % 9) == 8);
        chk("starve_p0_rvalid", p0_rvalid, ((i - 1) % 9) != 8);
        chk("starve_rdata", p0_rdata, (((i - 1) % 9) == 8) ? 32'hA5A50030 : 32'hA5A50020);
      end
      @(negedge clk);
    end
    p0_req = 0; p1_req = 0;
    #1;
    chk("starve_last_rvalid", p1_rvalid, 1);
    @(negedge clk);

    // Locked burst from p1 while p0 keeps requesting
    p0_req = 1; p0_addr = 20'h00020;
    p1_req = 1; p1_lock = 1; p1_addr = 20'h00100;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("pre_burst_p0_gnt", p0_gnt, 1);
      chk("pre_burst_p1_gnt", p1_gnt, 0);
      @(negedge clk);
    end
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("burst_p1_gnt", p1_gnt, 1);
      chk("burst_p0_gnt", p0_gnt, 0);
      chk("burst_mem_addr", mem_addr, 20'h00100 + 20'(k));
      if (k > 0) begin
        chk("burst_p1_rvalid", p1_rvalid, 1);
        chk("burst_p1_rdata", p1_rdata, 32'hA5A50100 + 32'(k - 1));
        chk("burst_p0_rvalid", p0_rvalid, 0);
      end
      @(negedge clk);
      p1_addr = 20'h00101 + 20'(k);
    end
    p1_req = 0;
    #1;
    chk("burst_idle_p1_gnt", p1_gnt, 0);
    chk("burst_idle_p0_gnt", p0_gnt, 0);
    chk("burst_idle_mem_we", mem_we, 0);
    chk("burst_idle_addr", mem_addr, 20'h00103);
    chk("burst_last_rvalid", p1_rvalid, 1);
    chk("burst_last_rdata", p1_rdata, 32'hA5A50103);
    @(negedge clk);
    p1_lock = 0;
    #1;
    chk("unlock_p0_gnt", p0_gnt, 0);
    chk("unlock_p1_rvalid", p1_rvalid, 0);
    @(negedge clk);
    #1;
    chk("post_burst_p0_gnt", p0_gnt, 1);
    chk("post_burst_mem_addr", mem_addr, 20'h00020);
    @(negedge clk);
    p0_req = 0;
    #1;
`ifdef MEM_ARB_STATS_EN
    chk("stats_p0_cnt", p0_cnt, 27);
    chk("stats_p1_cnt", p1_cnt, 6);
    chk("stats_starve", starve_cnt, 3);
`endif
    @(negedge clk);

    // p1 enters a locked read, then reset hits while the read is pending
    p1_req = 1; p1_lock = 1; p1_addr = 20'h00101;
    #1;
    chk("rst_p1_gnt", p1_gnt, 1);
    @(negedge clk);
    rstn = 0;
    #1;
    chk("rst_pending_rvalid", p1_rvalid, 1);
    chk("rst_gnt_masked", p1_gnt, 0);
    @(negedge clk);
    rstn = 1; p1_req = 0; p1_lock = 0; p0_req = 1; p0_addr = 20'h00020;
    #1;
    chk("rst_rvalid_cleared", p1_rvalid, 0);
    chk("rst_arb_p0_gnt", p0_gnt, 1);
`ifdef MEM_ARB_STATS_EN
    chk("rst_p0_cnt", p0_cnt, 0);
    chk("rst_p1_cnt", p1_cnt, 0);
    chk("rst_starve", starve_cnt, 0);
`endif
    @(negedge clk);
    p0_req = 0;
    repeat (2) @(negedge clk);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule
